// File: rtl/mem_stage_unit_pkg.sv
// rtl/mem_stage_unit_pkg.sv - shared constants and types for the MEM stage
package mem_stage_unit_pkg;

  // MEM-stage handshake FSM encoding
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [31:0] WORD_ZERO              = 32'h0000_0000;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_stage_unit_mem_wb_reg.sv
// rtl/mem_stage_unit_mem_wb_reg.sv - MEM/WB pipeline register with load and bubble
//
// Purpose: holds the instruction handed to write-back.
//   load       : capture controls, destination and ALU result
//   load_rdata : with load, also capture rdata_d into read_data_q
//   bubble     : clear reg_write_q only, other fields hold
//   neither    : everything holds
// Ports: clk, rst (async active-low), load, load_rdata, bubble,
//        *_d inputs, *_q outputs.
module mem_wb_reg
  import mem_stage_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        load_rdata,
  input  logic        bubble,
  input  logic        reg_write_d,
  input  logic        mem_to_reg_d,
  input  logic [4:0]  dst_d,
  input  logic [31:0] alu_result_d,
  input  logic [31:0] rdata_d,
  output logic        reg_write_q,
  output logic        mem_to_reg_q,
  output logic [4:0]  dst_q,
  output logic [31:0] alu_result_q,
  output logic [31:0] read_data_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      dst_q        <= 5'd0;
      alu_result_q <= WORD_ZERO;
      read_data_q  <= WORD_ZERO;
    end else if (load) begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      dst_q        <= dst_d;
      alu_result_q <= alu_result_d;
      if (load_rdata) begin
        read_data_q <= rdata_d;
      end
    end else if (bubble) begin
      reg_write_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MEM stage: data memory req/ack handshake, stall, MEM/WB
//
// Purpose: consumes EX/MEM outputs, drives a multi-cycle data memory,
//   stalls upstream while an access is outstanding, and feeds MEM/WB.
// Ports:
//   clk, rst (async active-low)
//   EX/MEM in : mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in,
//               dst_in, alu_result_in, store_data_in
//   memory    : dmem_req, dmem_we, dmem_addr, dmem_wdata (registered),
//               dmem_rdata, dmem_ack
//   control   : stall_out (combinational), bus_err_out (one-cycle pulse)
//   MEM/WB    : reg_write_out, mem_to_reg_out, dst_out, alu_result_out,
//               read_data_out
// Build option: MISALIGN_TRAP_EN - refuse accesses with address bits [1:0]
//   non-zero and flag them on bus_err_out instead of issuing.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic [4:0]  dst_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic        bus_err_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic [4:0]  dst_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] read_data_out
);

  state_t state, next_state;

  logic [CNT_W-1:0] cnt;
  logic             held_reg_write;
  logic             held_mem_to_reg;
  logic [4:0]       held_dst;

  logic access_req;
  logic misalign;
  logic timeout_hit;
  logic issue, complete, abort, trap;
  logic wb_load, wb_load_rdata, wb_bubble;

  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_dst;
  logic [31:0] wb_alu_result;

  assign access_req = mem_read_in | mem_write_in;

`ifdef MISALIGN_TRAP_EN
  assign misalign = |alu_result_in[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Ack is checked before the timeout so a coincident ack completes normally.
  always_comb begin
    next_state    = state;
    issue         = 1'b0;
    complete      = 1'b0;
    abort         = 1'b0;
    trap          = 1'b0;
    stall_out     = 1'b0;
    wb_load       = 1'b0;
    wb_load_rdata = 1'b0;
    wb_bubble     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access_req) begin
          wb_bubble = 1'b1;
          if (misalign) begin
            trap = 1'b1;
          end else begin
            issue      = 1'b1;
            stall_out  = 1'b1;
            next_state = ST_ACCESS;
          end
        end else begin
          wb_load = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack) begin
          complete      = 1'b1;
          wb_load       = 1'b1;
          wb_load_rdata = ~dmem_we;
          next_state    = ST_IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          wb_bubble  = 1'b1;
          next_state = ST_IDLE;
        end else begin
          stall_out = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The access request is latched at issue so completion does not rely on
  // EX/MEM staying frozen; dmem_addr doubles as the held ALU result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= WORD_ZERO;
      dmem_wdata      <= WORD_ZERO;
      bus_err_out     <= 1'b0;
      cnt             <= '0;
      held_reg_write  <= 1'b0;
      held_mem_to_reg <= 1'b0;
      held_dst        <= 5'd0;
    end else begin
      bus_err_out <= abort | trap;
      if (issue) begin
        dmem_req        <= 1'b1;
        dmem_we         <= mem_write_in;
        dmem_addr       <= alu_result_in;
        dmem_wdata      <= store_data_in;
        cnt             <= '0;
        held_reg_write  <= reg_write_in;
        held_mem_to_reg <= mem_to_reg_in;
        held_dst        <= dst_in;
      end else if (complete || abort) begin
        dmem_req <= 1'b0;
      end else if (state == ST_ACCESS) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    if (state == ST_ACCESS) begin
      wb_reg_write  = held_reg_write;
      wb_mem_to_reg = held_mem_to_reg;
      wb_dst        = held_dst;
      wb_alu_result = dmem_addr;
    end else begin
      wb_reg_write  = reg_write_in;
      wb_mem_to_reg = mem_to_reg_in;
      wb_dst        = dst_in;
      wb_alu_result = alu_result_in;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (wb_load),
    .load_rdata   (wb_load_rdata),
    .bubble       (wb_bubble),
    .reg_write_d  (wb_reg_write),
    .mem_to_reg_d (wb_mem_to_reg),
    .dst_d        (wb_dst),
    .alu_result_d (wb_alu_result),
    .rdata_d      (dmem_rdata),
    .reg_write_q  (reg_write_out),
    .mem_to_reg_q (mem_to_reg_out),
    .dst_q        (dst_out),
    .alu_result_q (alu_result_out),
    .read_data_q  (read_data_out)
  );

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - directed self-checking bench for mem_stage_unit
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic [4:0]  dst_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall_out, bus_err_out;
  logic        reg_write_out, mem_to_reg_out;
  logic [4:0]  dst_out;
  logic [31:0] alu_result_out, read_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_unit #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .reg_write_in   (reg_write_in),
    .mem_to_reg_in  (mem_to_reg_in),
    .dst_in         (dst_in),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .stall_out      (stall_out),
    .bus_err_out    (bus_err_out),
    .reg_write_out  (reg_write_out),
    .mem_to_reg_out (mem_to_reg_out),
    .dst_out        (dst_out),
    .alu_result_out (alu_result_out),
    .read_data_out  (read_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] sd);
    mem_read_in   = rd;
    mem_write_in  = wr;
    reg_write_in  = rw;
    mem_to_reg_in = m2r;
    dst_in        = dst;
    alu_result_in = alu;
    store_data_in = sd;
  endtask

  task automatic set_nop();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    rst        = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    set_nop();
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_buserr", bus_err_out, 0);
    check("rst_regwr", reg_write_out, 0);
    check("rst_rdata", read_data_out, 0);
    tick();
    tick();
    rst = 1'b1;

    // Non-memory op passes straight through
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    #1;
    check("nop_stall", stall_out, 0);
    tick();
    check("nop_regwr", reg_write_out, 1);
    check("nop_dst", dst_out, 5);
    check("nop_alu", alu_result_out, 32'h1234);
    check("nop_rdata_hold", read_data_out, 0);

    // Load, ack in the fourth ACCESS cycle: four stall cycles
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ld_stall", stall_out, 1);
      tick();
      check("ld_req", dmem_req, 1);
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_we", dmem_we, 0);
      check("ld_bubble", reg_write_out, 0);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("ld_ack_stall", stall_out, 0);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    set_nop();
    check("ld_done_req", dmem_req, 0);
    check("ld_rdata", read_data_out, 32'hDEADBEEF);
    check("ld_m2r", mem_to_reg_out, 1);
    check("ld_regwr", reg_write_out, 1);
    check("ld_dst", dst_out, 7);
    check("ld_alu", alu_result_out, 32'h100);

    // Store, immediate ack: one stall cycle
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h200, 32'hA5A5A5A5);
    #1;
    check("st_stall", stall_out, 1);
    tick();
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    check("st_addr", dmem_addr, 32'h200);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h55555555;
    #1;
    check("st_ack_stall", stall_out, 0);
    tick();
    dmem_ack = 1'b0;
    set_nop();
    check("st_done_req", dmem_req, 0);
    check("st_regwr", reg_write_out, 0);
    check("st_rdata_hold", read_data_out, 32'hDEADBEEF);

    // Timeout with TIMEOUT_CYCLES=4: abort in the fifth ACCESS cycle
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h300, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_stall", stall_out, 1);
      check("to_buserr_idle", bus_err_out, 0);
      tick();
    end
    check("to_abort_stall", stall_out, 0);
    tick();
    set_nop();
    check("to_buserr", bus_err_out, 1);
    check("to_req", dmem_req, 0);
    check("to_bubble", reg_write_out, 0);
    tick();
    check("to_buserr_pulse", bus_err_out, 0);

    // Ack arriving on the timeout cycle wins
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h500, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    #1;
    check("race_stall", stall_out, 0);
    tick();
    dmem_ack = 1'b0;
    set_nop();
    check("race_buserr", bus_err_out, 0);
    check("race_rdata", read_data_out, 32'h0BADF00D);
    check("race_regwr", reg_write_out, 1);

    // Ack while IDLE is ignored
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("idle_ack_req", dmem_req, 0);
    check("idle_ack_rdata", read_data_out, 32'h0BADF00D);

    // Reset in the middle of an access
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h400, 32'h0);
    tick();
    check("mid_req", dmem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_req", dmem_req, 0);
    check("arst_addr", dmem_addr, 0);
    check("arst_rdata", read_data_out, 0);
    check("arst_dst", dst_out, 0);
    tick();
    tick();
    set_nop();
    rst        = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h77777777;
    #1;
    check("late_ack_stall", stall_out, 0);
    tick();
    dmem_ack = 1'b0;
    check("late_ack_req", dmem_req, 0);
    check("late_ack_rdata", read_data_out, 0);
    check("late_ack_buserr", bus_err_out, 0);

    // Misaligned load
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 32'h10, 32'h0);
    tick();
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h102, 32'h0);
`ifdef MISALIGN_TRAP_EN
    #1;
    check("mis_stall", stall_out, 0);
    tick();
    set_nop();
    check("mis_req", dmem_req, 0);
    check("mis_buserr", bus_err_out, 1);
    check("mis_bubble", reg_write_out, 0);
`else
    #1;
    check("mis_stall", stall_out, 1);
    tick();
    check("mis_req", dmem_req, 1);
    check("mis_addr", dmem_addr, 32'h102);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    tick();
    dmem_ack = 1'b0;
    set_nop();
    check("mis_rdata", read_data_out, 32'h12345678);
    check("mis_buserr", bus_err_out, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Takes the control bits, ALU result and store data, and drives a multi-cycle data memory through a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in ACCESS without ack before abort; 0 disables the timeout.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (rst==0 resets)
- mem_read_in  input  1  load request from EX/MEM
- mem_write_in  input  1  store request from EX/MEM
- reg_write_in  input  1  register-write control from EX/MEM
- mem_to_reg_in  input  1  write-back select from EX/MEM
- dst_in  input  5  destination register number
- alu_result_in  input  32  ALU result; used as memory address
- store_data_in  input  32  store data (forwarded src B)
- dmem_req  output  1  memory request, level, registered
- dmem_we  output  1  1=write, 0=read; valid while dmem_req
- dmem_addr  output  32  word address; held stable while dmem_req
- dmem_wdata  output  32  store data; held stable while dmem_req
- dmem_rdata  input  32  read data; valid in the dmem_ack cycle
- dmem_ack  input  1  one-cycle completion strobe from memory
- stall_out  output  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
- bus_err_out  output  1  one-cycle pulse on timeout abort
- reg_write_out  output  1  MEM/WB register-write control
- mem_to_reg_out  output  1  MEM/WB write-back select
- dst_out  output  5  MEM/WB destination register
- alu_result_out  output  32  MEM/WB ALU result
- read_data_out  output  32  MEM/WB load data

Behaviour:
- States: IDLE, ACCESS.
- Reset (asynchronous, rst low):
  - state=IDLE, counter=0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, bus_err_out=0.
  - All MEM/WB outputs 0.
  - Takes effect immediately, including mid-access; the outstanding access is abandoned and a late ack is ignored.
- IDLE, no access (mem_read_in=0, mem_write_in=0):
  - stall_out=0.
  - Next edge: MEM/WB loads reg_write_in, mem_to_reg_in, dst_in, alu_result_in; read_data_out unchanged.
  - Single-cycle, no bubble.
- IDLE, access requested:
  - stall_out=1 combinationally in the same cycle.
  - Next edge: state=ACCESS, dmem_req=1, dmem_addr=alu_result_in, dmem_wdata=store_data_in, counter=0.
  - dmem_we=mem_write_in; write wins if both requests are set.
  - MEM/WB loads a bubble (reg_write_out=0; other fields hold).
- ACCESS, dmem_ack=0:
  - stall_out=1; dmem_* held stable; counter increments.
  - MEM/WB holds a bubble.
- ACCESS, dmem_ack=1:
  - stall_out=0 in that cycle, so EX/MEM advances at the same edge.
  - Next edge: state=IDLE, dmem_req=0.
  - MEM/WB loads the held instruction's controls and alu_result; read_data_out=dmem_rdata if it was a read.
- Latency: memory instruction occupies MEM for 1 + (cycles to ack); an immediate next-cycle ack gives 2 cycles.
- Timeout (TIMEOUT_CYCLES>0): counter reaches TIMEOUT_CYCLES with no ack →
  - Next edge: state=IDLE, dmem_req=0, bus_err_out=1 for one cycle.
  - MEM/WB gets a bubble; stall_out=0 in the abort cycle.
- Ack in the same cycle as timeout: ack wins, no bus_err_out.
- dmem_ack in IDLE: ignored.
- stall_out never depends on dmem_rdata.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - An access with alu_result_in[1:0]!=0 in IDLE is not issued: dmem_req stays 0, no stall.
  - bus_err_out pulses 1 at the next edge.
  - MEM/WB loads a bubble.
- Undefined: address bits [1:0] are passed unchanged on dmem_addr; no check.

Decomposition:
- Shared package/header constant_values.vh:
  - State encodings for IDLE/ACCESS.
  - WORD_ZERO, already in that header.
  - Default TIMEOUT_CYCLES.
- One natural sub-module: mem_wb_reg, the MEM/WB pipeline register with load and bubble inputs.
- The FSM, handshake and counter stay in mem_stage_unit.

Test Plan:
- Non-memory op: reg_write_in=1, dst_in=5, alu_result_in=0x1234 → stall_out=0; next edge reg_write_out=1, dst_out=5, alu_result_out=0x1234.
- Load, ack 3 cycles after req: alu_result_in=0x100, dmem_rdata=0xDEADBEEF at ack →
  - dmem_addr=0x100 and stable, dmem_we=0.
  - stall_out high for 4 cycles.
  - read_data_out=0xDEADBEEF, mem_to_reg_out=1.
- Store, immediate ack: store_data_in=0xA5A5A5A5 → dmem_we=1, dmem_wdata=0xA5A5A5A5, stall 1 cycle, reg_write_out=0.
- Timeout, TIMEOUT_CYCLES=4, no ack → bus_err_out pulses once ~5 cycles after req; dmem_req drops; stall released; MEM/WB bubble.
- Reset mid-ACCESS: rst low 2 cycles, then ack → outputs 0 asynchronously, ack ignored, state IDLE.
- MISALIGN_TRAP_EN defined, load at 0x102 → dmem_req stays 0, bus_err_out=1 at next edge, reg_write_out=0.
